// File: rtl/regfile_write_arbiter.sv
// Owns the regfile write port: sweeps INIT_VALUE into every entry after reset, then
// round-robin shares the port between ALU (req0) and load (req1) writeback, dropping x0 writes.
module regfile_write_arbiter #(
  parameter int                     register_count = 32,
  parameter int                     data_length    = 32,
  parameter logic [data_length-1:0] INIT_VALUE     = {data_length{1'b0}},
  localparam int                    AW             = $clog2(register_count)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [AW-1:0]          req0_addr,
  input  logic [data_length-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [AW-1:0]          req1_addr,
  input  logic [data_length-1:0] req1_data,
  output logic                   req1_ready,
  output logic [AW-1:0]          w_addr_reg,
  output logic [data_length-1:0] w_data_reg,
  output logic                   w_ctrl_reg,
  output logic                   init_done,
  output logic                   wr_pending
);

  localparam logic [1:0]    ST_INIT  = 2'b01;
  localparam logic [1:0]    ST_RUN   = 2'b10;
  localparam logic [AW-1:0] LAST_IDX = AW'(register_count - 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   last_grant_q, last_grant_d;
  logic [AW-1:0]          w_addr_q, w_addr_d;
  logic [data_length-1:0] w_data_q, w_data_d;
  logic                   w_ctrl_q, w_ctrl_d;
  logic                   init_done_q, init_done_d;
  logic                   gnt0_s, gnt1_s;

  // Round-robin grant: on contention the requester that did not win last time goes first.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == ST_RUN) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state: init sweep, then registered writes from the granted requester.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    w_ctrl_d     = 1'b0;
    init_done_d  = init_done_q;
    case (state_q)
      ST_INIT: begin
        w_ctrl_d = 1'b1;
        w_addr_d = cnt_q;
        w_data_d = INIT_VALUE;
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = {AW{1'b0}};
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        // x0 writes are accepted but never enabled, so x0 keeps reading zero.
        if (gnt0_s) begin
          w_addr_d     = req0_addr;
          w_data_d     = req0_data;
          w_ctrl_d     = (req0_addr != {AW{1'b0}});
          last_grant_d = 1'b0;
        end else if (gnt1_s) begin
          w_addr_d     = req1_addr;
          w_data_d     = req1_data;
          w_ctrl_d     = (req1_addr != {AW{1'b0}});
          last_grant_d = 1'b1;
        end else begin
          w_ctrl_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_INIT;
        cnt_d        = {AW{1'b0}};
        last_grant_d = 1'b1;
        w_ctrl_d     = 1'b0;
        init_done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also kills any write registered but not yet landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= {AW{1'b0}};
      last_grant_q <= 1'b1;
      w_addr_q     <= {AW{1'b0}};
      w_data_q     <= {data_length{1'b0}};
      w_ctrl_q     <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      w_ctrl_q     <= w_ctrl_d;
      init_done_q  <= init_done_d;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign w_addr_reg = w_addr_q;
  assign w_data_reg = w_data_q;
  assign w_ctrl_reg = w_ctrl_q;
  assign wr_pending = w_ctrl_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a request-queue reference model predicts grants
// and regfile writes; a separate monitor checks every registered write as it appears.
module tb_regfile_write_arbiter;

  localparam int RC = 32;
  localparam int DL = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DL-1:0] data;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DL-1:0] data;
    int            due;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DL-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] w_addr_reg;
  logic [DL-1:0] w_data_reg;
  logic          w_ctrl_reg, init_done, wr_pending;

  req_t q0[$];
  req_t q1[$];
  wr_t  expq[$];
  int   gnt_log[$];
  logic [DL-1:0] tb_rf    [RC];
  logic [DL-1:0] model_rf [RC];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sweep_k = 0;
  logic last_m = 1'b1;
  logic [DL-1:0] last0_data, last1_data;

  regfile_write_arbiter #(
    .register_count(RC),
    .data_length(DL),
    .INIT_VALUE({DL{1'b0}})
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg), .w_ctrl_reg(w_ctrl_reg),
    .init_done(init_done), .wr_pending(wr_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle count, sweep progress and the regfile that the write port drives.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) sweep_k <= 0;
    else if (sweep_k < 1000) sweep_k <= sweep_k + 1;
    if (w_ctrl_reg) tb_rf[w_addr_reg] <= w_data_reg;
  end

  // Requesters present the head of their queue, holding it until it is accepted.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_addr = q0[0].addr; req0_data = q0[0].data;
    end else begin
      req0_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_addr = q1[0].addr; req1_data = q1[0].data;
    end else begin
      req1_valid = 1'b0;
    end
  end

  // Reference model: predicts readiness and grants, queues the expected write port activity.
  always @(negedge clk) begin
    logic e0, e1, done_m;
    req_t r;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      last_m = 1'b1;
      chk("rst_init_done", init_done, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
    end else begin
      done_m = (sweep_k >= RC);
      chk("init_done", init_done, done_m);
      if (done_m) begin
        if (req0_valid && req1_valid) begin
          if (last_m) e0 = 1'b1; else e1 = 1'b1;
        end else if (req0_valid) e0 = 1'b1;
        else if (req1_valid) e1 = 1'b1;
      end
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      if (e0) begin
        r = q0.pop_front();
        last_m = 1'b0;
        gnt_log.push_back(0);
        if (r.addr != 0) expq.push_back('{r.addr, r.data, cyc + 1});
      end else if (e1) begin
        r = q1.pop_front();
        last_m = 1'b1;
        gnt_log.push_back(1);
        if (r.addr != 0) expq.push_back('{r.addr, r.data, cyc + 1});
      end
    end
  end

  // Monitor: every registered write must match the next expected one, in its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("wr_ctrl", w_ctrl_reg, 1);
      chk("wr_addr", w_addr_reg, e.addr);
      chk("wr_data", w_data_reg, e.data);
      model_rf[e.addr] = e.data;
    end else begin
      chk("wr_idle_ctrl", w_ctrl_reg, 0);
    end
    chk("wr_pending", wr_pending, w_ctrl_reg);
  end

  task automatic assert_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    expq.delete();
    #1;
    chk("rst_w_ctrl", w_ctrl_reg, 0);
    chk("rst_w_addr", w_addr_reg, 0);
    chk("rst_w_data", w_data_reg, 0);
    chk("rst_done_now", init_done, 0);
    chk("rst_rdy0_now", req0_ready, 0);
    chk("rst_rdy1_now", req1_ready, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < RC; i++) expq.push_back('{AW'(i), {DL{1'b0}}, cyc + 1 + i});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || expq.size() > 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk(name, (n < 400), 1);
  endtask

  task automatic compare_rf(input string name);
    int bad = 0;
    for (int i = 0; i < RC; i++) if (tb_rf[i] !== model_rf[i]) bad++;
    chk(name, bad, 0);
    chk("x0_zero", tb_rf[0], 0);
  endtask

  initial begin
    req_t r;
    rst = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    #1;
    chk("por_w_ctrl", w_ctrl_reg, 0);
    chk("por_init_done", init_done, 0);
    repeat (3) @(posedge clk);
    release_reset();
    drain("sweep_drain");
    compare_rf("rf_after_sweep");

    // Single ALU write to x5.
    q0.push_back('{5'd5, 32'hDEADBEEF});
    drain("t1_drain");
    chk("t1_x5", tb_rf[5], 32'hDEADBEEF);

    // Both requesters busy: grants must alternate.
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      last0_data = $urandom; last1_data = $urandom;
      q0.push_back('{5'd1, last0_data});
      q1.push_back('{5'd2, last1_data});
    end
    drain("t2_drain");
    chk("t2_grants", gnt_log.size(), 8);
    for (int i = 1; i < gnt_log.size(); i++) chk("t2_alternate", gnt_log[i], 1 - gnt_log[i-1]);
    chk("t2_x1", tb_rf[1], last0_data);
    chk("t2_x2", tb_rf[2], last1_data);

    // Load writeback to x0 is accepted and dropped.
    gnt_log.delete();
    q1.push_back('{5'd0, 32'h00001234});
    drain("t3_drain");
    chk("t3_granted", gnt_log.size(), 1);
    chk("t3_x0", tb_rf[0], 0);

    // Random traffic on both requesters.
    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 1) == 1 && q0.size() < 3) begin
        r.addr = AW'($urandom_range(0, RC - 1)); r.data = $urandom; q0.push_back(r);
      end
      if ($urandom_range(0, 1) == 1 && q1.size() < 3) begin
        r.addr = AW'($urandom_range(0, RC - 1)); r.data = $urandom; q1.push_back(r);
      end
    end
    drain("rand_drain");
    compare_rf("rf_after_random");

    // Reset during RUN traffic, requests queued during INIT, reset again at sweep entry 10.
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{AW'(3 + i), $urandom});
      q1.push_back('{AW'(10 + i), $urandom});
    end
    repeat (2) @(posedge clk);
    assert_reset();
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{AW'(20 + i), $urandom});
      q1.push_back('{AW'(25 + i), $urandom});
    end
    begin
      int n = 0;
      while (sweep_k < 10 && n < 100) begin
        @(posedge clk);
        #3;
        n++;
      end
      chk("reach_entry10", (n < 100), 1);
    end
    chk("pending_at_sweep", (q0.size() > 0), 1);
    assert_reset();
    repeat (2) @(posedge clk);
    release_reset();
    drain("final_drain");
    compare_rf("rf_after_resets");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
